// File: rtl/df_sync_pkg.sv
// Shared constants and helpers for the dataflow start/done sequencer.
package df_sync_pkg;

  localparam int DEF_NUM_PROC     = 3;
  localparam int DEF_MAX_INFLIGHT = 2;
  localparam int DEF_WDOG_CYCLES  = 1024;

  // Width of a counter that must hold values 0..max_val inclusive.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/df_proc_track.sv
// Per-process tracker: ready-seen bit, outstanding-done counter and protocol error term.
module df_proc_track
  import df_sync_pkg::*;
#(
  parameter int MAX_INFLIGHT = DEF_MAX_INFLIGHT
) (
  input  logic clock,
  input  logic reset,
  input  logic start_en,
  input  logic clear,
  input  logic retire,
  input  logic inflight_zero,
  input  logic proc_ready,
  input  logic proc_done,
  output logic proc_start,
  output logic acc,
  output logic ready_seen,
  output logic pending_next,
  output logic err_term
);

  localparam int CW = cnt_width(MAX_INFLIGHT);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_INFLIGHT);

  logic [CW-1:0] done_cnt;
  logic [CW-1:0] cnt_next;
  logic          overflow;
  logic          stray;
  logic          inc;
  logic          dec;

  assign proc_start = start_en & ~ready_seen;
  assign acc        = proc_start & proc_ready;

  // A done is legitimate only once this process has taken an iteration.
  assign overflow = proc_done & (done_cnt == MAX_CNT);
  assign stray    = proc_done & inflight_zero & ~ready_seen & ~acc;
  assign err_term = overflow | stray;
  assign inc      = proc_done & ~err_term;
  assign dec      = retire & (done_cnt != '0);

  // NOTE: cnt_next gets its default first so no path through the block leaves it unassigned (no latch).
  always_comb begin
    cnt_next = done_cnt;
    if (inc && !dec)      cnt_next = done_cnt + 1'b1;
    else if (dec && !inc) cnt_next = done_cnt - 1'b1;
  end

  assign pending_next = (cnt_next != '0);

  // NOTE: state registers use non-blocking assignments and clear asynchronously on reset low.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ready_seen <= 1'b0;
      done_cnt   <= '0;
    end else begin
      if (clear)    ready_seen <= 1'b0;
      else if (acc) ready_seen <= 1'b1;
      done_cnt <= cnt_next;
    end
  end

endmodule

// File: rtl/dataflow_start_sync.sv
// Start/done sequencer for a task-level dataflow region of NUM_PROC processes.
// Optional stall watchdog enabled by defining DF_STALL_WDOG_EN.
module dataflow_start_sync
  import df_sync_pkg::*;
#(
  parameter int NUM_PROC     = DEF_NUM_PROC,
  parameter int MAX_INFLIGHT = DEF_MAX_INFLIGHT,
  parameter int WDOG_CYCLES  = DEF_WDOG_CYCLES
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                ap_start,
  output logic                ap_ready,
  output logic                ap_done,
  input  logic                ap_continue,
  output logic                ap_idle,
  output logic [NUM_PROC-1:0] proc_start,
  input  logic [NUM_PROC-1:0] proc_ready,
  input  logic [NUM_PROC-1:0] proc_done,
  input  logic [NUM_PROC-1:0] proc_idle,
  output logic [NUM_PROC-1:0] ready_seen,
  output logic                err,
  output logic                stall
);

  localparam int CW = cnt_width(MAX_INFLIGHT);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_INFLIGHT);

  logic [CW-1:0]       inflight;
  logic [NUM_PROC-1:0] acc;
  logic [NUM_PROC-1:0] pending_next;
  logic [NUM_PROC-1:0] err_term;
  logic                start_en;
  logic                retire;
  logic                inflight_zero;

  assign inflight_zero = (inflight == '0);
  assign start_en      = ap_start & (inflight < MAX_CNT);
  assign ap_ready      = start_en & (&(ready_seen | acc));
  assign retire        = ap_done & ap_continue;
  assign ap_idle       = inflight_zero & ~(|ready_seen) & (&proc_idle);

  for (genvar i = 0; i < NUM_PROC; i++) begin : g_proc
    df_proc_track #(
      .MAX_INFLIGHT(MAX_INFLIGHT)
    ) u_track (
      .clock        (clock),
      .reset        (reset),
      .start_en     (start_en),
      .clear        (ap_ready),
      .retire       (retire),
      .inflight_zero(inflight_zero),
      .proc_ready   (proc_ready[i]),
      .proc_done    (proc_done[i]),
      .proc_start   (proc_start[i]),
      .acc          (acc[i]),
      .ready_seen   (ready_seen[i]),
      .pending_next (pending_next[i]),
      .err_term     (err_term[i])
    );
  end

  // ap_done tracks the post-update counters, so queued completions keep it high across a retire.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      inflight <= '0;
      ap_done  <= 1'b0;
      err      <= 1'b0;
    end else begin
      if (ap_ready && !retire)                       inflight <= inflight + 1'b1;
      else if (retire && !ap_ready && !inflight_zero) inflight <= inflight - 1'b1;
      ap_done <= &pending_next;
      err     <= err | (|err_term);
    end
  end

`ifdef DF_STALL_WDOG_EN
  localparam int WW = $clog2(WDOG_CYCLES) + 1;
  localparam logic [WW-1:0] WDOG_LIMIT = WW'(WDOG_CYCLES);

  logic [WW-1:0] wdog_cnt;
  logic          wdog_event;
  logic          wdog_active;

  assign wdog_event  = (|acc) | (|proc_done) | retire;
  assign wdog_active = ~inflight_zero | ap_start;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wdog_cnt <= '0;
      stall    <= 1'b0;
    end else begin
      if (wdog_event)                                   wdog_cnt <= '0;
      else if (wdog_active && wdog_cnt != WDOG_LIMIT)   wdog_cnt <= wdog_cnt + 1'b1;
      if (!wdog_event && wdog_active && wdog_cnt == WDOG_LIMIT - 1'b1) stall <= 1'b1;
    end
  end
`else
  logic unused_wdog;
  assign unused_wdog = ^WDOG_CYCLES;
  assign stall       = 1'b0;
`endif

endmodule

// File: tb/tb_dataflow_start_sync.sv
// Directed bench for dataflow_start_sync: vector table plus multi-cycle corner sequences.
module tb_dataflow_start_sync;

  logic       clock = 1'b0;
  logic       reset;
  logic       ap_start, ap_ready, ap_done, ap_continue, ap_idle;
  logic [2:0] proc_start, proc_ready, proc_done, proc_idle, ready_seen;
  logic       err, stall;

  int checks = 0;
  int errors = 0;

  dataflow_start_sync #(
    .NUM_PROC    (3),
    .MAX_INFLIGHT(2),
    .WDOG_CYCLES (16)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .ap_start   (ap_start),
    .ap_ready   (ap_ready),
    .ap_done    (ap_done),
    .ap_continue(ap_continue),
    .ap_idle    (ap_idle),
    .proc_start (proc_start),
    .proc_ready (proc_ready),
    .proc_done  (proc_done),
    .proc_idle  (proc_idle),
    .ready_seen (ready_seen),
    .err        (err),
    .stall      (stall)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       st;
    logic       cont;
    logic [2:0] rdy;
    logic [2:0] dn;
    logic [2:0] idl;
    logic [2:0] ps;
    logic       ar;
    logic       ad;
    logic       ai;
    logic [2:0] rs;
    logic       er;
  } vec_t;

  vec_t vecs[22];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic drive(input logic st, input logic cont, input logic [2:0] rdy, input logic [2:0] dn);
    ap_start    = st;
    ap_continue = cont;
    proc_ready  = rdy;
    proc_done   = dn;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic cycle_chk(input logic st, input logic cont, input logic [2:0] rdy,
                           input logic [2:0] dn, input string tag,
                           input logic [2:0] ps, input logic ar, input logic ad);
    drive(st, cont, rdy, dn);
    @(negedge clock);
    check({tag, " proc_start"}, proc_start, ps);
    check({tag, " ap_ready"}, ap_ready, ar);
    check({tag, " ap_done"}, ap_done, ad);
    tick();
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 3'b000, 3'b000);
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = '{1'b0, 1'b0, 3'b000, 3'b000, 3'b111, 3'b000, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 3'b000, 3'b000, 3'b101, 3'b000, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 3'b000, 3'b000, 3'b111, 3'b111, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 3'b001, 3'b000, 3'b111, 3'b111, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 3'b000, 3'b000, 3'b111, 3'b110, 1'b0, 1'b0, 1'b0, 3'b001, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 3'b100, 3'b000, 3'b111, 3'b110, 1'b0, 1'b0, 1'b0, 3'b001, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 3'b000, 3'b000, 3'b111, 3'b010, 1'b0, 1'b0, 1'b0, 3'b101, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 3'b010, 3'b000, 3'b111, 3'b010, 1'b1, 1'b0, 1'b0, 3'b101, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 3'b000, 3'b000, 3'b111, 3'b000, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 3'b000, 3'b001, 3'b111, 3'b000, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 3'b000, 3'b000, 3'b111, 3'b000, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 3'b000, 3'b010, 3'b111, 3'b000, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 3'b000, 3'b100, 3'b111, 3'b000, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0};
    for (int i = 13; i < 18; i++)
      vecs[i] = '{1'b0, 1'b0, 3'b000, 3'b000, 3'b111, 3'b000, 1'b0, 1'b1, 1'b0, 3'b000, 1'b0};
    vecs[18] = '{1'b0, 1'b1, 3'b000, 3'b000, 3'b111, 3'b000, 1'b0, 1'b1, 1'b0, 3'b000, 1'b0};
    vecs[19] = '{1'b0, 1'b0, 3'b000, 3'b000, 3'b111, 3'b000, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0};
    vecs[20] = '{1'b0, 1'b0, 3'b000, 3'b010, 3'b111, 3'b000, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0};
    vecs[21] = '{1'b0, 1'b0, 3'b000, 3'b000, 3'b111, 3'b000, 1'b0, 1'b0, 1'b1, 3'b000, 1'b1};

    reset     = 1'b0;
    proc_idle = 3'b111;
    drive(1'b0, 1'b0, 3'b000, 3'b000);
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;

    // Staggered readies, done merge with a held ap_done, stray done after retire.
    for (int i = 0; i < 22; i++) begin
      drive(vecs[i].st, vecs[i].cont, vecs[i].rdy, vecs[i].dn);
      proc_idle = vecs[i].idl;
      @(negedge clock);
      check($sformatf("row%0d proc_start", i), proc_start, vecs[i].ps);
      check($sformatf("row%0d ap_ready", i), ap_ready, vecs[i].ar);
      check($sformatf("row%0d ap_done", i), ap_done, vecs[i].ad);
      check($sformatf("row%0d ap_idle", i), ap_idle, vecs[i].ai);
      check($sformatf("row%0d ready_seen", i), ready_seen, vecs[i].rs);
      check($sformatf("row%0d err", i), err, vecs[i].er);
      tick();
    end
    proc_idle = 3'b111;

    // Reset asserted mid-iteration clears everything, then a late done is flagged.
    cycle_chk(1'b1, 1'b0, 3'b111, 3'b000, "midrst accept", 3'b111, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 3'b000, 3'b000);
    #2 reset = 1'b0;
    #1;
    check("rst err", err, 1'b0);
    check("rst ready_seen", ready_seen, 3'b000);
    check("rst ap_done", ap_done, 1'b0);
    check("rst proc_start", proc_start, 3'b000);
    check("rst ap_ready", ap_ready, 1'b0);
    check("rst ap_idle", ap_idle, 1'b1);
    check("rst stall", stall, 1'b0);
    tick();
    reset = 1'b1;
    cycle_chk(1'b0, 1'b0, 3'b000, 3'b001, "late done", 3'b000, 1'b0, 1'b0);
    @(negedge clock);
    check("late done err", err, 1'b1);
    tick();
    do_reset();

    // Inflight cap: third start is held off until the first iteration retires.
    cycle_chk(1'b1, 1'b0, 3'b111, 3'b000, "cap it1", 3'b111, 1'b1, 1'b0);
    cycle_chk(1'b1, 1'b0, 3'b111, 3'b000, "cap it2", 3'b111, 1'b1, 1'b0);
    cycle_chk(1'b1, 1'b0, 3'b111, 3'b000, "cap full", 3'b000, 1'b0, 1'b0);
    cycle_chk(1'b1, 1'b0, 3'b000, 3'b111, "cap done", 3'b000, 1'b0, 1'b0);
    cycle_chk(1'b1, 1'b1, 3'b111, 3'b000, "cap retire", 3'b000, 1'b0, 1'b1);
    cycle_chk(1'b1, 1'b0, 3'b111, 3'b000, "cap it3", 3'b111, 1'b1, 1'b0);

    // Two queued completions: ap_done survives the first retire, drops after the second.
    cycle_chk(1'b0, 1'b0, 3'b000, 3'b111, "q done1", 3'b000, 1'b0, 1'b0);
    cycle_chk(1'b0, 1'b0, 3'b000, 3'b111, "q done2", 3'b000, 1'b0, 1'b1);
    cycle_chk(1'b0, 1'b1, 3'b000, 3'b000, "q ret1", 3'b000, 1'b0, 1'b1);
    cycle_chk(1'b0, 1'b0, 3'b000, 3'b000, "q hold", 3'b000, 1'b0, 1'b1);
    cycle_chk(1'b0, 1'b1, 3'b000, 3'b000, "q ret2", 3'b000, 1'b0, 1'b1);
    @(negedge clock);
    check("q final ap_done", ap_done, 1'b0);
    check("q final ap_idle", ap_idle, 1'b1);
    check("q final err", err, 1'b0);
    tick();

    // Overflow on P1: err sets, its counter saturates at 2.
    cycle_chk(1'b1, 1'b0, 3'b111, 3'b000, "ovf it1", 3'b111, 1'b1, 1'b0);
    cycle_chk(1'b1, 1'b0, 3'b111, 3'b000, "ovf it2", 3'b111, 1'b1, 1'b0);
    cycle_chk(1'b0, 1'b0, 3'b000, 3'b010, "ovf d1", 3'b000, 1'b0, 1'b0);
    cycle_chk(1'b0, 1'b0, 3'b000, 3'b010, "ovf d2", 3'b000, 1'b0, 1'b0);
    @(negedge clock);
    check("ovf err before", err, 1'b0);
    tick();
    cycle_chk(1'b0, 1'b0, 3'b000, 3'b010, "ovf d3", 3'b000, 1'b0, 1'b0);
    @(negedge clock);
    check("ovf err after", err, 1'b1);
    tick();
    cycle_chk(1'b0, 1'b0, 3'b000, 3'b101, "ovf d02a", 3'b000, 1'b0, 1'b0);
    cycle_chk(1'b0, 1'b0, 3'b000, 3'b101, "ovf d02b", 3'b000, 1'b0, 1'b1);
    cycle_chk(1'b0, 1'b1, 3'b000, 3'b000, "ovf ret1", 3'b000, 1'b0, 1'b1);
    cycle_chk(1'b0, 1'b1, 3'b000, 3'b000, "ovf ret2", 3'b000, 1'b0, 1'b1);
    @(negedge clock);
    check("ovf final ap_done", ap_done, 1'b0);
    check("ovf final err", err, 1'b1);
    tick();
    do_reset();

    // Watchdog: ap_start held with no process accepting.
    drive(1'b1, 1'b0, 3'b000, 3'b000);
    for (int k = 1; k <= 17; k++) begin
      @(negedge clock);
      if (k == 16) check("wdog before", stall, 1'b0);
      if (k == 17) begin
`ifdef DF_STALL_WDOG_EN
        check("wdog stall", stall, 1'b1);
`else
        check("wdog stall", stall, 1'b0);
`endif
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
